// File: rtl/cpu_ctrl_fsm.sv
// Purpose : multi-cycle control FSM behind the instruction decoder. It drives nsel, vsel,
//           the datapath load enables, asel/bsel and write, and keeps a retired counter
//           and a sticky undefined-instruction flag.
// Latency : w is low for this many cycles after s is sampled: MOV imm 2, MOV shift/MVN 4,
//           CMP 4, ADD/AND 5, undefined 2.
// Backpressure: w=1 only in WAIT. s is sampled in WAIT and ignored in every other state.
//           Holding s high issues back to back, with exactly one WAIT cycle between
//           instructions.
//
// Optional feature macro: HALT_EN
//   Defined   : opcode 111 enters HALT. HALT holds w=0 and halted=1 and is left only by reset.
//   Undefined : opcode 111 is undefined and goes to ERR. halted is tied to 0.
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   s                  start request, sampled only in WAIT
//   opcode[2:0], op[1:0]  decoder fields, latched when an instruction is issued
//   w                  ready/wait (1 in WAIT)
//   nsel[1:0]          register select to the decoder (00=Rm, 01=Rd, 10=Rn)
//   vsel[1:0]          writeback mux (00=C, 01=PC, 10=sximm8, 11=mdata)
//   loada/loadb/loadc/loads  datapath load enables
//   asel, bsel         ALU operand selects
//   write              register-file write enable
//   err                sticky undefined-instruction flag
//   retired[CNT_W-1:0] completed-instruction count, wraps modulo 2^CNT_W
//   halted             1 in HALT (HALT_EN builds only)

module cpu_ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic [2:0]       opcode,
  input  logic [1:0]       op,
  output logic             w,
  output logic [1:0]       nsel,
  output logic [1:0]       vsel,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic             write,
  output logic             err,
  output logic [CNT_W-1:0] retired,
  output logic             halted
);

  localparam logic [3:0] S_WAIT   = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_GET_A  = 4'd2;
  localparam logic [3:0] S_GET_B  = 4'd3;
  localparam logic [3:0] S_ALU    = 4'd4;
  localparam logic [3:0] S_CMP    = 4'd5;
  localparam logic [3:0] S_WR_REG = 4'd6;
  localparam logic [3:0] S_WR_IMM = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;
`ifdef HALT_EN
  localparam logic [3:0] S_HALT   = 4'd9;
`endif

  logic [3:0]       state;
  logic [3:0]       next_state;
  logic [2:0]       opc_q;
  logic [1:0]       op_q;
  logic             err_q;
  logic [CNT_W-1:0] retired_q;
  logic             issue;
  logic             retire;

  assign issue  = (state == S_WAIT) && s;
  // Every one of these states hands back to WAIT on the next edge, so its
  // presence marks the completing cycle of a retiring instruction.
  assign retire = (state == S_WR_REG) || (state == S_WR_IMM) || (state == S_CMP);

  // Next-state logic. Decode and the operand-path branches look only at the
  // fields captured at issue, so the decoder may move on freely once s is taken.
  always_comb begin
    next_state = S_WAIT;
    case (state)
      S_WAIT:   next_state = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        case ({opc_q, op_q})
          5'b110_10:                       next_state = S_WR_IMM;
          5'b110_00, 5'b101_11:            next_state = S_GET_B;
          5'b101_00, 5'b101_01, 5'b101_10: next_state = S_GET_A;
          default: begin
            next_state = S_ERR;
`ifdef HALT_EN
            if (opc_q == 3'b111) next_state = S_HALT;
`endif
          end
        endcase
      end
      S_GET_A:  next_state = S_GET_B;
      S_GET_B:  next_state = (op_q == 2'b01) ? S_CMP : S_ALU;
      S_ALU:    next_state = S_WR_REG;
      S_CMP:    next_state = S_WAIT;
      S_WR_REG: next_state = S_WAIT;
      S_WR_IMM: next_state = S_WAIT;
      S_ERR:    next_state = S_WAIT;
`ifdef HALT_EN
      S_HALT:   next_state = S_HALT;
`endif
      default:  next_state = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_WAIT;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q <= 3'b000;
      op_q  <= 2'b00;
    end else if (issue) begin
      opc_q <= opcode;
      op_q  <= op;
    end
  end

  // err is raised on leaving ERR and held until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == S_ERR) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Moore outputs, decoded from the state register alone.
  always_comb begin
    w     = 1'b0;
    nsel  = 2'b01;
    vsel  = 2'b00;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    write = 1'b0;
    case (state)
      S_WAIT:   w = 1'b1;
      S_GET_A: begin
        nsel  = 2'b10;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = 2'b00;
        loadb = 1'b1;
      end
      S_ALU: begin
        loadc = 1'b1;
        // MOV shift and MVN take no A operand, so force the ALU A input to zero.
        asel  = ((opc_q == 3'b110) && (op_q == 2'b00)) ||
                ((opc_q == 3'b101) && (op_q == 2'b11));
      end
      S_CMP:    loads = 1'b1;
      S_WR_REG: begin
        nsel  = 2'b01;
        vsel  = 2'b00;
        write = 1'b1;
      end
      S_WR_IMM: begin
        nsel  = 2'b10;
        vsel  = 2'b10;
        write = 1'b1;
      end
      default: ;
    endcase
  end

  assign err     = err_q;
  assign retired = retired_q;

`ifdef HALT_EN
  assign halted = (state == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Control state machine sitting directly downstream of the instruction decoder. It consumes the decoder's opcode/op fields and drives the register-file select (nsel, fed back into the decoder), the datapath load enables and the mux selects, sequencing each instruction over multiple cycles. A start/wait handshake (s/w) paces instruction issue. It also keeps a retired-instruction counter and a sticky undefined-instruction flag.

Parameters:
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
s  in  1  start: request to execute the instruction currently decoded
opcode  in  3  from decoder, instr[15:13]
op  in  2  from decoder, instr[12:11]
w  out  1  wait/ready; 1 only in WAIT state
nsel  out  2  register select to decoder: 00=Rm, 01=Rd, 10=Rn
vsel  out  2  writeback mux: 00=C, 01=PC, 10=sximm8, 11=mdata
loada  out  1  load A register
loadb  out  1  load B register
loadc  out  1  load C register
loads  out  1  load status flags
asel  out  1  1 = ALU A input forced to zero
bsel  out  1  1 = ALU B input from sximm5
write  out  1  register-file write enable
err  out  1  sticky undefined-instruction flag
retired  out  CNT_W  count of completed instructions
halted  out  1  1 in HALT state (see Optional Feature)

Behaviour:
- Moore FSM; all outputs are decoded from state only.
- Default output values (any state not listed, and during reset): nsel=01, vsel=00, loads/write/asel/bsel=0.
- Reset (asynchronous, rst_n=0): state=WAIT, w=1, err=0, retired=0, halted=0, latched opcode/op=0. Takes effect immediately, including mid-instruction; no partial write completes after reset assertion.
- WAIT: w=1. If s=1 at the clock edge, latch opcode/op into internal registers and go to DECODE. Otherwise stay in WAIT.
- s is ignored in every state except WAIT. Holding s high gives back-to-back issue, with exactly one WAIT cycle between instructions.
- DECODE: branch on the latched fields, never the live inputs:
  - 110/10 MOV imm -> WR_IMM
  - 110/00 MOV shift, 101/11 MVN -> GET_B
  - 101/00 ADD, 101/01 CMP, 101/10 AND -> GET_A
  - anything else -> ERR
- GET_A: nsel=10, loada=1 -> GET_B.
- GET_B: nsel=00, loadb=1 -> ALU if op is not 01, else CMP.
- ALU: loadc=1; asel=1 for MOV shift and MVN, else 0 -> WR_REG.
- CMP: loads=1 -> WAIT.
- WR_REG: nsel=01, vsel=00, write=1 -> WAIT.
- WR_IMM: nsel=10, vsel=10, write=1 -> WAIT.
- ERR: set err=1 (stays set until reset) -> WAIT. An ERR instruction does not increment retired.
- retired increments by 1 on every transition from WR_REG, WR_IMM or CMP into WAIT. It wraps modulo 2^CNT_W.
- Latency, counted as the number of cycles w is low after s is sampled:
  - MOV imm: 2
  - MOV shift, MVN: 4
  - CMP: 4
  - ADD, AND: 5
  - undefined: 2
- loada, loadb, loadc, loads and write are never asserted in WAIT, DECODE or ERR.

Optional Feature:
HALT_EN
- Defined: latched opcode 111 in DECODE goes to HALT. HALT has w=0, halted=1 and all enables 0. It is left only by reset; s is ignored. HALT does not increment retired.
- Undefined: opcode 111 is undefined and goes to ERR. halted is tied to 0.

Test Plan:
1. Reset, then s=1 with opcode=110, op=10 -> w low 2 cycles; WR_IMM cycle shows nsel=10, vsel=10, write=1; retired=1.
2. ADD (101/00) -> enables in order: loada (nsel=10), loadb (nsel=00), loadc (asel=0), write (nsel=01, vsel=00); w low 5 cycles; retired=1.
3. CMP (101/01) then MVN (101/11) with s held high -> CMP asserts loads once and never write; MVN asserts loadc with asel=1, then write; exactly one WAIT cycle between the two; retired=2.
4. opcode=000 -> err=1 after 2 cycles, retired unchanged. A following valid MOV imm executes normally and err stays 1.
5. rst_n pulsed low during the ALU cycle of ADD -> outputs immediately w=1, write=0, loadc=0, retired=0, err=0; no write ever occurs for that ADD.
6. CNT_W=2, four MOV imm instructions -> retired goes 1, 2, 3, 0. With HALT_EN defined, opcode=111 -> halted=1 and w=0 persist for 10+ cycles despite s=1, and clear on reset.
